// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1-to-2 stream demultiplexer.
// Holds the route FSM state encoding and default widths.
package demux_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } demux_state_t;

  localparam int DEMUX_WIDTH_DEF = 8;
  localparam int DEMUX_CNT_W_DEF = 16;

endpackage

// File: rtl/stream_slot.sv
// One-entry registered stream slot: holds a single beat until drained.
// Ports: clk, rst, i_load/i_data/i_last (fill), i_ready (consumer),
//        o_valid/o_data/o_last (output beat), o_free (can accept now).
module stream_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;

  // Free when empty or being drained this cycle.
  assign o_free  = !r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      // Refill wins over drain, so valid stays high.
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid & i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_2.sv
// Registered 1-to-2 stream demux; route picked by s on first beat.
// Ports: clk, rst, x_* input stream with s select, y0_*/y1_* outputs,
//        pkt_cnt0/pkt_cnt1 completed-packet counters per output.
module stream_demux_1_2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int CNT_W = DEMUX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [WIDTH-1:0] x_data,
  input  logic             x_last,
  input  logic             s,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_last,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_last,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  demux_state_t r_state;
  demux_state_t w_state_nxt;
  logic         r_sel_q;
  logic         w_target;
  logic         w_free0;
  logic         w_free1;
  logic         w_accept;
  logic         w_load0;
  logic         w_load1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // In IDLE the live select steers; once locked, s is ignored.
  assign w_target = (r_state == LOCKED) ? r_sel_q : s;
  assign x_ready  = w_target ? w_free1 : w_free0;
  assign w_accept = x_valid & x_ready;
  assign w_load0  = w_accept & !w_target;
  assign w_load1  = w_accept & w_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept & !x_last) w_state_nxt = LOCKED;
      end
      LOCKED: begin
        if (w_accept & x_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_q <= 1'b0;
    end else if (r_state == IDLE && w_accept && !x_last) begin
      r_sel_q <= s;
    end
  end

  stream_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load0),
    .i_data  (x_data),
    .i_last  (x_last),
    .i_ready (y0_ready),
    .o_valid (y0_valid),
    .o_data  (y0_data),
    .o_last  (y0_last),
    .o_free  (w_free0)
  );

  stream_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load1),
    .i_data  (x_data),
    .i_last  (x_last),
    .i_ready (y1_ready),
    .o_valid (y1_valid),
    .o_data  (y1_data),
    .o_last  (y1_last),
    .o_free  (w_free1)
  );

  // Counters wrap naturally; a packet completes when its last beat leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (y0_valid & y0_ready & y0_last) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (y1_valid & y1_ready & y1_last) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Directed bench for stream_demux_1_2.
// Drives and samples 1 time unit after each rising edge.
module tb_stream_demux_1_2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic [7:0]  x_data = 8'h00;
  logic        x_last = 1'b0;
  logic        s = 1'b0;
  logic        y0_valid;
  logic        y0_ready = 1'b0;
  logic [7:0]  y0_data;
  logic        y0_last;
  logic        y1_valid;
  logic        y1_ready = 1'b0;
  logic [7:0]  y1_data;
  logic        y1_last;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stream_demux_1_2 #(.WIDTH(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x_data   (x_data),
    .x_last   (x_last),
    .s        (s),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y0_data  (y0_data),
    .y0_last  (y0_last),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .y1_data  (y1_data),
    .y1_last  (y1_last),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b%b exp=00", y0_valid, y1_valid);
    end
    total++;
    if (y0_data !== 8'h00 || y1_data !== 8'h00 ||
        y0_last !== 1'b0 || y1_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h exp=00/00", y0_data, y1_data);
    end
    total++;
    if (pkt_cnt0 !== 16'h0 || pkt_cnt1 !== 16'h0) begin
      bad++;
      $display("FAIL reset_cnt got=%h/%h exp=0/0", pkt_cnt0, pkt_cnt1);
    end
    total++;
    if (x_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_xready got=%b exp=1", x_ready);
    end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_three_beat();
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_valid = 1'b1;
      x_data  = d[i];
      x_last  = (i == 2);
      total++;
      if (x_ready !== 1'b1) begin
        bad++;
        $display("FAIL p3_xready beat=%0d got=%b exp=1", i, x_ready);
      end
      cyc();
      total++;
      if (y0_valid !== 1'b1 || y0_data !== d[i] ||
          y0_last !== (i == 2) || y1_valid !== 1'b0) begin
        bad++;
        $display("FAIL p3_beat%0d got=v%b d=%h l=%b y1v=%b exp=v1 d=%h",
                 i, y0_valid, y0_data, y0_last, y1_valid, d[i]);
      end
    end
    x_valid = 1'b0;
    x_last  = 1'b0;
    cyc();
    total++;
    if (pkt_cnt0 !== 16'd1 || y0_valid !== 1'b0) begin
      bad++;
      $display("FAIL p3_cnt got=%0d v=%b exp=1 v=0", pkt_cnt0, y0_valid);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1;
      s       = (i == 0) ? 1'b1 : 1'b0;
      x_data  = 8'hA0 + 8'(i);
      x_last  = (i == 3);
      total++;
      if (x_ready !== 1'b1) begin
        bad++;
        $display("FAIL lock_xready beat=%0d got=%b exp=1", i, x_ready);
      end
      cyc();
      total++;
      if (y1_valid !== 1'b1 || y1_data !== 8'hA0 + 8'(i) ||
          y0_valid !== 1'b0) begin
        bad++;
        $display("FAIL lock_beat%0d got=y1v%b d=%h y0v=%b exp=y1v1 d=%h y0v0",
                 i, y1_valid, y1_data, y0_valid, 8'hA0 + 8'(i));
      end
    end
    x_valid = 1'b0;
    x_last  = 1'b0;
    s       = 1'b0;
    cyc();
    total++;
    if (pkt_cnt1 !== 16'd1 || pkt_cnt0 !== 16'd1) begin
      bad++;
      $display("FAIL lock_cnt got=%0d/%0d exp=1/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_stall();
    y0_ready = 1'b0;
    s        = 1'b0;
    x_valid  = 1'b1;
    x_data   = 8'h55;
    x_last   = 1'b1;
    cyc();
    x_data = 8'h66;
    total++;
    if (x_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_xready got=%b exp=0", x_ready);
    end
    cyc();
    cyc();
    total++;
    if (y0_valid !== 1'b1 || y0_data !== 8'h55) begin
      bad++;
      $display("FAIL stall_hold got=v%b d=%h exp=v1 d=55", y0_valid, y0_data);
    end
    y0_ready = 1'b1;
    #1;
    total++;
    if (x_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_passthru got=%b exp=1", x_ready);
    end
    cyc();
    total++;
    if (y0_valid !== 1'b1 || y0_data !== 8'h66 || pkt_cnt0 !== 16'd2) begin
      bad++;
      $display("FAIL stall_refill got=v%b d=%h c=%0d exp=v1 d=66 c=2",
               y0_valid, y0_data, pkt_cnt0);
    end
    x_valid = 1'b0;
    x_last  = 1'b0;
    cyc();
    total++;
    if (y0_valid !== 1'b0 || pkt_cnt0 !== 16'd3) begin
      bad++;
      $display("FAIL stall_drain got=v%b c=%0d exp=v0 c=3", y0_valid, pkt_cnt0);
    end
  endtask

  task automatic test_alternate();
    logic [15:0] c0;
    logic [15:0] c1;
    c0 = 16'd3;
    c1 = 16'd1;
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1;
      x_last  = 1'b1;
      s       = i[0];
      x_data  = 8'(i + 1);
      cyc();
      total++;
      if (i[0] == 1'b0) begin
        if (y0_valid !== 1'b1 || y0_data !== 8'(i + 1) || y1_valid !== 1'b0) begin
          bad++;
          $display("FAIL alt_beat%0d got=y0v%b d=%h y1v%b exp=y0v1 d=%h y1v0",
                   i, y0_valid, y0_data, y1_valid, 8'(i + 1));
        end
      end else begin
        if (y1_valid !== 1'b1 || y1_data !== 8'(i + 1) || y0_valid !== 1'b0) begin
          bad++;
          $display("FAIL alt_beat%0d got=y1v%b d=%h y0v%b exp=y1v1 d=%h y0v0",
                   i, y1_valid, y1_data, y0_valid, 8'(i + 1));
        end
      end
    end
    x_valid = 1'b0;
    x_last  = 1'b0;
    s       = 1'b0;
    cyc();
    total++;
    if (pkt_cnt0 !== c0 + 16'd2 || pkt_cnt1 !== c1 + 16'd2) begin
      bad++;
      $display("FAIL alt_cnt got=%0d/%0d exp=%0d/%0d",
               pkt_cnt0, pkt_cnt1, c0 + 16'd2, c1 + 16'd2);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    #1;
    total++;
    if (pkt_cnt0 !== 16'h0 || pkt_cnt1 !== 16'h0) begin
      bad++;
      $display("FAIL wrap_clear got=%h/%h exp=0/0", pkt_cnt0, pkt_cnt1);
    end
    cyc();
    rst = 1'b0;
    y0_ready = 1'b1;
    s        = 1'b0;
    x_last   = 1'b1;
    x_data   = 8'h5A;
    x_valid  = 1'b1;
    repeat (65535) cyc();
    x_valid = 1'b0;
    cyc();
    total++;
    if (pkt_cnt0 !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_full got=%h exp=ffff", pkt_cnt0);
    end
    x_valid = 1'b1;
    cyc();
    x_valid = 1'b0;
    cyc();
    total++;
    if (pkt_cnt0 !== 16'h0000 || pkt_cnt1 !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_zero got=%h/%h exp=0000/0000", pkt_cnt0, pkt_cnt1);
    end
    x_last = 1'b0;
  endtask

  task automatic test_reset_mid();
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    x_valid  = 1'b1;
    x_last   = 1'b1;
    s        = 1'b0;
    cyc();
    s = 1'b1;
    cyc();
    x_valid = 1'b0;
    cyc();
    total++;
    if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
      bad++;
      $display("FAIL rm_pre got=%0d/%0d exp=1/1", pkt_cnt0, pkt_cnt1);
    end
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    x_valid  = 1'b1;
    x_last   = 1'b1;
    s        = 1'b0;
    x_data   = 8'hC0;
    cyc();
    s      = 1'b1;
    x_last = 1'b0;
    x_data = 8'hC1;
    cyc();
    x_valid = 1'b0;
    total++;
    if (y0_valid !== 1'b1 || y1_valid !== 1'b1) begin
      bad++;
      $display("FAIL rm_full got=%b%b exp=11", y0_valid, y1_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (y0_valid !== 1'b0 || y1_valid !== 1'b0 ||
        pkt_cnt0 !== 16'h0 || pkt_cnt1 !== 16'h0) begin
      bad++;
      $display("FAIL rm_async got=v%b%b c=%0d/%0d exp=v00 c=0/0",
               y0_valid, y1_valid, pkt_cnt0, pkt_cnt1);
    end
    cyc();
    rst = 1'b0;
    y0_ready = 1'b1;
    x_valid  = 1'b1;
    s        = 1'b0;
    x_last   = 1'b0;
    x_data   = 8'h77;
    cyc();
    total++;
    if (y0_valid !== 1'b1 || y0_data !== 8'h77 || y1_valid !== 1'b0) begin
      bad++;
      $display("FAIL rm_new got=y0v%b d=%h y1v%b exp=y0v1 d=77 y1v0",
               y0_valid, y0_data, y1_valid);
    end
    x_last = 1'b1;
    x_data = 8'h78;
    cyc();
    x_valid = 1'b0;
    x_last  = 1'b0;
    cyc();
    total++;
    if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd0) begin
      bad++;
      $display("FAIL rm_cnt got=%0d/%0d exp=1/0", pkt_cnt0, pkt_cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_three_beat();
    test_lock();
    test_stall();
    test_alternate();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
